br_puf_ctrl: RTL and testbench
==============================

Name: br_puf_ctrl

Overview:
Sequencer for the 32-ring bistable-ring PUF array. It accepts a challenge via a start/done handshake and drives the array's challenge and reset inputs. It releases the rings, waits for them to settle, samples the asynchronous response several times through a synchronizer, and reports a per-bit majority vote plus a per-bit stability mask. It sits between the bus/host logic and the PUF array instance.

Parameters:
WIDTH, 32, challenge/response width (array size)
RST_CYCLES, 4, cycles puf_reset is held high before a measurement
SETTLE_CYCLES, 16, cycles after reset release before first sample; includes the 2-cycle synchronizer latency
NUM_SAMPLES, 5, number of response samples; must be odd, 1..15
CNT_W, 8, width of the shared phase counter; must hold max(RST_CYCLES, SETTLE_CYCLES, NUM_SAMPLES)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
start  input  1  request a measurement; sampled only in IDLE
challenge_in  input  WIDTH  challenge, captured on the accepted start
busy  output  1  high from the cycle after accepted start through the DONE cycle
done  output  1  one-cycle pulse; response/stable valid from this cycle
response  output  WIDTH  majority-voted response, held until next done
stable  output  WIDTH  bit=1 when all NUM_SAMPLES samples of that bit agreed
puf_challenge  output  WIDTH  to the array challenge input; registered
puf_reset  output  1  to the array reset input; active-high, registered
puf_rsp  input  WIDTH  raw array response; asynchronous to clk

Behaviour:
- Reset (reset_n=0, async): state=IDLE, response=0, stable=0, done=0, busy=0, puf_challenge=0, puf_reset=1, counters and vote accumulators=0. Reset mid-measurement aborts it; no done is produced.
- puf_rsp passes through a 2-flop synchronizer per bit, reset to 0. Samples always use the synchronized value.
- FSM states: IDLE, RST, SETTLE, SAMPLE, DONE.
- IDLE: puf_reset=1. If start=1, capture challenge_in into puf_challenge, clear accumulators, load counter, go to RST. Otherwise stay.
- RST: puf_reset=1 for exactly RST_CYCLES cycles, then go to SETTLE.
- SETTLE: puf_reset=0 for exactly SETTLE_CYCLES cycles, then go to SAMPLE.
- SAMPLE: puf_reset=0. Each cycle, add the synchronized bit to a per-bit ones counter (width clog2(NUM_SAMPLES+1)). After exactly NUM_SAMPLES cycles, go to DONE.
- DONE: single cycle. done=1, puf_reset=1. Register response[i] = (ones[i] > NUM_SAMPLES/2) and stable[i] = (ones[i]==0 or ones[i]==NUM_SAMPLES). Next state is IDLE.
- Timing: accepted start at edge 0 puts the FSM in RST from cycle 1. done is high in cycle RST_CYCLES+SETTLE_CYCLES+NUM_SAMPLES+1, i.e. cycle 26 with defaults. busy is high in cycles 1..26.
- start during busy is ignored, not queued. start in the DONE cycle is ignored. start in the first IDLE cycle after DONE is accepted, giving back-to-back measurements.
- puf_challenge holds its value after DONE until the next accepted start.
- response and stable change only in the DONE cycle.
- Counter wrap: the phase counter is reloaded on every state entry. Loading 0 for any phase parameter is illegal; guard it with an elaboration-time check.

Decomposition:
- Shared package br_puf_pkg:
  - FSM state enum (IDLE, RST, SETTLE, SAMPLE, DONE)
  - default constants PUF_WIDTH=32, PUF_RST_CYCLES, PUF_SETTLE_CYCLES, PUF_NUM_SAMPLES
  - function clog2 for the vote-counter width
- One sub-module: br_puf_vote. It holds the per-bit synchronizer, the ones-counters (clear, accumulate enable) and the majority/stability compare. Instantiated once with a WIDTH parameter.

Test Plan:
- Stub array returning challenge XOR 32'hA5A5_0F0F after reset release. start with challenge_in=32'h1234_5678 -> done at cycle 26, response=32'hB791_5977, stable=32'hFFFF_FFFF, busy high cycles 1..26.
- Stub forces bit 0 to the sample pattern 1,0,1,1,0, all other bits constant 0. -> response bit0=1, stable=32'hFFFF_FFFE, other response bits 0.
- Second start pulsed at cycle 10 while busy -> ignored. Exactly one done at cycle 26; start at cycle 27 -> second done at cycle 53.
- reset_n dropped at cycle 15 (in SETTLE) -> same cycle puf_reset=1, busy=0, response/stable=0. No done appears within 40 cycles after reset_n rises without a new start.
- puf_reset trace for one measurement -> 1 in cycles 0..4, 0 in cycles 5..25, 1 in cycle 26 onward. puf_challenge stable from cycle 1 until the next accepted start.

Source files
------------

// File: rtl/br_puf_pkg.sv
// Shared types and defaults for the bistable-ring PUF sequencer.
package br_puf_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRst,
    StSettle,
    StSample,
    StDone
  } puf_state_e;

  localparam int unsigned PUF_WIDTH         = 32;
  localparam int unsigned PUF_RST_CYCLES    = 4;
  localparam int unsigned PUF_SETTLE_CYCLES = 16;
  localparam int unsigned PUF_NUM_SAMPLES   = 5;

  // Ceiling log2, with a floor of 1 so a single-sample counter still has a bit.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((32'd1 << result) < value) begin
      result = result + 1;
    end
    if (result == 0) begin
      result = 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/br_puf_vote.sv
// Per-bit response synchronizer, ones-counters and majority/stability vote.
module br_puf_vote
  import br_puf_pkg::*;
#(
  parameter int unsigned WIDTH       = PUF_WIDTH,
  parameter int unsigned NUM_SAMPLES = PUF_NUM_SAMPLES
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i_rsp,
  input  logic             i_clear,
  input  logic             i_acc_en,
  input  logic             i_latch,
  output logic [WIDTH-1:0] o_response,
  output logic [WIDTH-1:0] o_stable
);

  localparam int unsigned VoteW = clog2(NUM_SAMPLES + 1);
  localparam logic [VoteW-1:0] Half = VoteW'(NUM_SAMPLES / 2);
  localparam logic [VoteW-1:0] All  = VoteW'(NUM_SAMPLES);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [VoteW-1:0] r_ones [WIDTH];
  logic [VoteW-1:0] w_ones_nxt [WIDTH];
  logic [WIDTH-1:0] r_response;
  logic [WIDTH-1:0] r_stable;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= i_rsp;
      r_sync2 <= r_sync1;
    end
  end

  // Count including the current sample so the vote can latch on the last sample cycle.
  always_comb begin
    for (int i = 0; i < int'(WIDTH); i++) begin
      w_ones_nxt[i] = r_ones[i] + VoteW'(r_sync2[i]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        r_ones[i] <= '0;
      end
    end else if (i_clear) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        r_ones[i] <= '0;
      end
    end else if (i_acc_en) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        r_ones[i] <= w_ones_nxt[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_response <= '0;
      r_stable   <= '0;
    end else if (i_latch) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        r_response[i] <= (w_ones_nxt[i] > Half);
        r_stable[i]   <= (w_ones_nxt[i] == '0) || (w_ones_nxt[i] == All);
      end
    end
  end

  assign o_response = r_response;
  assign o_stable   = r_stable;

endmodule

// File: rtl/br_puf_ctrl.sv
// Measurement sequencer for the bistable-ring PUF array: reset, settle, sample, vote.
module br_puf_ctrl
  import br_puf_pkg::*;
#(
  parameter int unsigned WIDTH         = PUF_WIDTH,
  parameter int unsigned RST_CYCLES    = PUF_RST_CYCLES,
  parameter int unsigned SETTLE_CYCLES = PUF_SETTLE_CYCLES,
  parameter int unsigned NUM_SAMPLES   = PUF_NUM_SAMPLES,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] challenge_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] response,
  output logic [WIDTH-1:0] stable,
  output logic [WIDTH-1:0] puf_challenge,
  output logic             puf_reset,
  input  logic [WIDTH-1:0] puf_rsp
);

  if (RST_CYCLES == 0 || SETTLE_CYCLES == 0 || NUM_SAMPLES == 0) begin : g_zero_phase
    $error("br_puf_ctrl: phase lengths must be non-zero");
  end
  if ((NUM_SAMPLES % 2) == 0 || NUM_SAMPLES > 15) begin : g_bad_samples
    $error("br_puf_ctrl: NUM_SAMPLES must be odd and at most 15");
  end
  if (CNT_W < 32 && (RST_CYCLES > (32'd1 << CNT_W) || SETTLE_CYCLES > (32'd1 << CNT_W) ||
                     NUM_SAMPLES > (32'd1 << CNT_W))) begin : g_cnt_narrow
    $error("br_puf_ctrl: CNT_W too narrow for the phase lengths");
  end

  puf_state_e       r_state;
  puf_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_last;
  logic             w_clear;
  logic             w_acc_en;
  logic             w_latch;
  logic             w_capture;
  logic [WIDTH-1:0] r_puf_challenge;
  logic             r_puf_reset;

  assign w_last = (r_cnt == '0);

  // Counter holds remaining cycles minus one and is reloaded on every state entry.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt - CNT_W'(1);
    w_clear     = 1'b0;
    w_acc_en    = 1'b0;
    w_latch     = 1'b0;
    w_capture   = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_cnt_nxt = '0;
        if (start) begin
          w_state_nxt = StRst;
          w_cnt_nxt   = CNT_W'(RST_CYCLES - 1);
          w_clear     = 1'b1;
          w_capture   = 1'b1;
        end
      end
      StRst: begin
        if (w_last) begin
          w_state_nxt = StSettle;
          w_cnt_nxt   = CNT_W'(SETTLE_CYCLES - 1);
        end
      end
      StSettle: begin
        if (w_last) begin
          w_state_nxt = StSample;
          w_cnt_nxt   = CNT_W'(NUM_SAMPLES - 1);
        end
      end
      StSample: begin
        w_acc_en = 1'b1;
        if (w_last) begin
          w_latch     = 1'b1;
          w_state_nxt = StDone;
          w_cnt_nxt   = '0;
        end
      end
      StDone: begin
        w_state_nxt = StIdle;
        w_cnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = StIdle;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= StIdle;
      r_cnt           <= '0;
      r_puf_challenge <= '0;
      r_puf_reset     <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_puf_reset <= !((w_state_nxt == StSettle) || (w_state_nxt == StSample));
      if (w_capture) begin
        r_puf_challenge <= challenge_in;
      end
    end
  end

  br_puf_vote #(
    .WIDTH      (WIDTH),
    .NUM_SAMPLES(NUM_SAMPLES)
  ) u_vote (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_rsp     (puf_rsp),
    .i_clear   (w_clear),
    .i_acc_en  (w_acc_en),
    .i_latch   (w_latch),
    .o_response(response),
    .o_stable  (stable)
  );

  assign busy          = (r_state != StIdle);
  assign done          = (r_state == StDone);
  assign puf_challenge = r_puf_challenge;
  assign puf_reset     = r_puf_reset;

endmodule

// File: tb/tb_br_puf_ctrl.sv
// Directed bench for br_puf_ctrl with a behavioural stub of the ring array.
module tb_br_puf_ctrl;

  localparam logic [31:0] StubKey = 32'hA5A5_0F0F;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [31:0] challenge_in;
  logic        busy;
  logic        done;
  logic [31:0] response;
  logic [31:0] stable;
  logic [31:0] puf_challenge;
  logic        puf_reset;
  logic [31:0] puf_rsp;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int base = 0;
  int mode = 0;
  int rc;

  br_puf_ctrl dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .challenge_in (challenge_in),
    .busy         (busy),
    .done         (done),
    .response     (response),
    .stable       (stable),
    .puf_challenge(puf_challenge),
    .puf_reset    (puf_reset),
    .puf_rsp      (puf_rsp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Mode 0: rings settle to challenge^key once released. Mode 1: bit 0 toggles 1,0,1,1,0
  // in cycles 19..23 so that the synchronized samples in cycles 21..25 carry that pattern.
  always_comb begin
    rc      = cyc - base;
    puf_rsp = '0;
    if (mode == 0) begin
      if (!puf_reset) puf_rsp = puf_challenge ^ StubKey;
    end else begin
      if (rc == 19 || rc == 21 || rc == 22) puf_rsp[0] = 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Runs one measurement; cycle 0 is the cycle start is high, ign is a cycle with a
  // spurious start pulse (or -1), ncyc is how many cycles after cycle 0 are observed.
  task automatic do_meas(input string tag, input logic [31:0] chal, input logic [31:0] exp_resp,
                         input logic [31:0] exp_stab, input int ign, input int ncyc);
    int          done_cyc;
    int          extra_done;
    logic        busy_ok;
    logic        prst_ok;
    logic        pch_ok;
    logic        hold_ok;
    logic [31:0] prev_resp;
    logic [31:0] prev_stab;
    logic [31:0] got_resp;
    logic [31:0] got_stab;
    @(negedge clk);
    start        = 1'b1;
    challenge_in = chal;
    base         = cyc;
    prev_resp    = response;
    prev_stab    = stable;
    done_cyc     = -1;
    extra_done   = 0;
    busy_ok      = 1'b1;
    prst_ok      = 1'b1;
    pch_ok       = 1'b1;
    hold_ok      = 1'b1;
    got_resp     = '0;
    got_stab     = '0;
    for (int n = 1; n <= ncyc; n++) begin
      @(negedge clk);
      start        = (n == ign);
      challenge_in = ~chal;
      if (busy !== (n <= 26)) busy_ok = 1'b0;
      if (puf_reset !== (n <= 4 || n >= 26)) prst_ok = 1'b0;
      if (puf_challenge !== chal) pch_ok = 1'b0;
      if (n < 26 && (response !== prev_resp || stable !== prev_stab)) hold_ok = 1'b0;
      if (done === 1'b1) begin
        if (done_cyc < 0) begin
          done_cyc = n;
          got_resp = response;
          got_stab = stable;
        end else begin
          extra_done++;
        end
      end
      if (n > 26 && (response !== got_resp || stable !== got_stab)) hold_ok = 1'b0;
    end
    start = 1'b0;
    check({tag, "_done_cycle"}, done_cyc, 26);
    check({tag, "_extra_done"}, extra_done, 0);
    check({tag, "_response"}, got_resp, exp_resp);
    check({tag, "_stable"}, got_stab, exp_stab);
    check({tag, "_busy_trace"}, {31'd0, busy_ok}, 32'd1);
    check({tag, "_puf_reset_trace"}, {31'd0, prst_ok}, 32'd1);
    check({tag, "_puf_challenge_hold"}, {31'd0, pch_ok}, 32'd1);
    check({tag, "_result_hold"}, {31'd0, hold_ok}, 32'd1);
  endtask

  typedef struct {
    logic [31:0] chal;
    logic [31:0] resp;
    logic [31:0] stab;
    int          ign;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int base1;
    int n_done;
    int n_busy;

    vecs[0] = '{chal: 32'h1234_5678, resp: 32'hB791_5977, stab: 32'hFFFF_FFFF, ign: -1};
    vecs[1] = '{chal: 32'h0000_0000, resp: 32'hA5A5_0F0F, stab: 32'hFFFF_FFFF, ign: 10};
    vecs[2] = '{chal: 32'hFFFF_FFFF, resp: 32'h5A5A_F0F0, stab: 32'hFFFF_FFFF, ign: 26};
    vecs[3] = '{chal: 32'hA5A5_0F0F, resp: 32'h0000_0000, stab: 32'hFFFF_FFFF, ign: 3};

    reset_n      = 1'b0;
    start        = 1'b0;
    challenge_in = '0;
    mode         = 0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_puf_reset", {31'd0, puf_reset}, 32'd1);
    check("rst_response", response, 32'd0);
    check("rst_stable", stable, 32'd0);
    check("rst_puf_challenge", puf_challenge, 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      do_meas($sformatf("vec%0d", i), vecs[i].chal, vecs[i].resp, vecs[i].stab, vecs[i].ign, 40);
    end

    // Back-to-back: second start lands in the first IDLE cycle after DONE (cycle 27).
    do_meas("b2b_first", 32'h1234_5678, 32'hB791_5977, 32'hFFFF_FFFF, 10, 26);
    base1 = base;
    do_meas("b2b_second", 32'h0F0F_F0F0, 32'hAAAA_FFFF, 32'hFFFF_FFFF, -1, 40);
    check("b2b_start_gap", base - base1, 27);

    mode = 1;
    do_meas("pattern", 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFE, -1, 40);
    mode = 0;

    // Abort mid-SETTLE with an asynchronous reset.
    @(negedge clk);
    start        = 1'b1;
    challenge_in = 32'hCAFE_F00D;
    base         = cyc;
    for (int n = 1; n <= 15; n++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("abort_puf_reset_before", {31'd0, puf_reset}, 32'd0);
    reset_n = 1'b0;
    #1;
    check("abort_puf_reset", {31'd0, puf_reset}, 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_response", response, 32'd0);
    check("abort_stable", stable, 32'd0);
    check("abort_puf_challenge", puf_challenge, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    n_done  = 0;
    n_busy  = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
      if (busy !== 1'b0) n_busy++;
    end
    check("abort_no_done", n_done, 0);
    check("abort_no_busy", n_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
